// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX oversampling front end.
// Holds the limits on the vote size and the helpers that decide whether a
// Prescale value can hold a centred sample window.
package uart_rx_pkg;

    localparam int N_SAMPLES_MAX = 7;

    // Smallest Prescale that still leaves room for an N-sample centred window.
    function automatic int PRESCALE_MIN_F(input int n);
        return n + 1;
    endfunction

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // An even Prescale of at least N+1 keeps the window [C-H, C+H] inside 0..P-1.
    function automatic logic is_legal_prescale(input int p, input int n);
        return ((p % 2) == 0) && (p >= PRESCALE_MIN_F(n));
    endfunction

endpackage

// File: rtl/uart_rx_oversampler_if.sv
// Control/status bundle between the RX bit sampler and the UART RX FSM.
// The FSM side (master) drives sample_en and Prescale and consumes the tick
// and vote outputs; the sampler side (slave) does the opposite.
// Optional macro NOISE_FLAG_EN adds the noise_flag signal.
interface uart_rx_oversampler_if #(
    parameter int PRESCALE_W = 6
) ();

    logic                  sample_en;
    logic [PRESCALE_W-1:0] Prescale;
    logic [PRESCALE_W-1:0] edge_count;
    logic                  bit_tick;
    logic                  sampled_bit;
    logic                  sampled_valid;
    logic                  cfg_err;
`ifdef NOISE_FLAG_EN
    logic                  noise_flag;
`endif

    modport master (
        output sample_en, Prescale,
`ifdef NOISE_FLAG_EN
        input  noise_flag,
`endif
        input  edge_count, bit_tick, sampled_bit, sampled_valid, cfg_err
    );

    modport slave (
        input  sample_en, Prescale,
`ifdef NOISE_FLAG_EN
        output noise_flag,
`endif
        output edge_count, bit_tick, sampled_bit, sampled_valid, cfg_err
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous RX pad.
// Resets to the idle mark level so a freshly reset receiver sees a quiet line.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw line through the chain; the last stage is the only one used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rx_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversampler.sv
// Parametrised RX bit sampler: owns the oversampling edge counter, takes
// N_SAMPLES samples centred in each bit period, majority-votes them and
// emits one bit per bit period to the UART RX FSM.
// Optional macro NOISE_FLAG_EN adds noise_flag, pulsed with sampled_valid
// when the samples of a bit were not unanimous.
module uart_rx_oversampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W  = 6,
    parameter int N_SAMPLES   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    uart_rx_oversampler_if.slave  bus
);

    localparam int H      = (N_SAMPLES - 1) / 2;
    localparam int ONES_W = clog2(N_SAMPLES + 1);
    localparam int SUM_W  = ONES_W + 1;

    if ((N_SAMPLES < 3) || (N_SAMPLES > N_SAMPLES_MAX) || ((N_SAMPLES % 2) == 0)) begin : g_bad_n_samples
        $error("N_SAMPLES must be odd and within 3..7");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be at least 2");
    end

    logic                  rx_s;
    logic [PRESCALE_W-1:0] edge_count_q;
    logic [PRESCALE_W-1:0] last_tick;
    logic                  cfg_err_q;
    logic                  sample_tick;
    logic                  last_sample;
    logic [ONES_W-1:0]     ones_q;
    logic [SUM_W-1:0]      vote_sum;
    logic                  sampled_bit_q;
    logic                  sampled_valid_q;
    int                    centre;
    int                    edge_i;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_in (RX_IN),
        .rx_s  (rx_s)
    );

    // Window decode: signed arithmetic so a small Prescale cannot wrap C-H below zero.
    always_comb begin
        last_tick   = bus.Prescale - PRESCALE_W'(1);
        centre      = int'(bus.Prescale >> 1);
        edge_i      = int'(edge_count_q);
        sample_tick = bus.sample_en && !cfg_err_q &&
                      (edge_i >= centre - H) && (edge_i <= centre + H);
        last_sample = (edge_i == centre + H);
        vote_sum    = SUM_W'(ones_q) + SUM_W'(rx_s);
    end

    // Edge counter; wrapping on >= rather than == recovers when Prescale shrinks below the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_count_q <= '0;
        end else if (!bus.sample_en) begin
            edge_count_q <= '0;
        end else if (edge_count_q >= last_tick) begin
            edge_count_q <= '0;
        end else begin
            edge_count_q <= edge_count_q + PRESCALE_W'(1);
        end
    end

    // Configuration check, registered so the window decode sees a stable flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= !is_legal_prescale(int'(bus.Prescale), N_SAMPLES);
        end
    end

    // Voter: accumulate ones across the window and resolve on the final sample tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q          <= '0;
            sampled_bit_q   <= 1'b1;
            sampled_valid_q <= 1'b0;
        end else begin
            sampled_valid_q <= 1'b0;
            if (!bus.sample_en) begin
                ones_q <= '0;
            end else if (sample_tick) begin
                if (last_sample) begin
                    sampled_bit_q   <= (vote_sum > SUM_W'(H));
                    sampled_valid_q <= 1'b1;
                    ones_q          <= '0;
                end else begin
                    ones_q <= ones_q + ONES_W'(rx_s);
                end
            end
        end
    end

`ifdef NOISE_FLAG_EN
    logic noise_flag_q;

    // Noise flag: the resolving vote saw a mix of ones and zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noise_flag_q <= 1'b0;
        end else begin
            noise_flag_q <= sample_tick && last_sample &&
                            (vote_sum != '0) && (vote_sum < SUM_W'(N_SAMPLES));
        end
    end

    assign bus.noise_flag = noise_flag_q;
`endif

    assign bus.edge_count    = edge_count_q;
    assign bus.bit_tick      = bus.sample_en && (edge_count_q == last_tick);
    assign bus.sampled_bit   = sampled_bit_q;
    assign bus.sampled_valid = sampled_valid_q;
    assign bus.cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Self-checking bench for uart_rx_oversampler.
// Two instances share clock, reset, RX line and controls: one with N_SAMPLES=3
// (main checks) and one with N_SAMPLES=5 (wide-window glitch vote).
// Expected votes are derived from the RX pattern and queued per instance.
// Build with NOISE_FLAG_EN defined to also check noise_flag.
module tb_uart_rx_oversampler;

    localparam int PW = 6;

    typedef struct {
        logic bit_v;
        logic noise;
        int   count;
    } vote_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          RX_IN;
    logic          sample_en;
    logic [PW-1:0] prescale;

    vote_t q3[$];
    vote_t q5[$];
    vote_t exp_v;
    logic  pat[64];
    int    m_count;
    logic  m_cfg;
    int    vectors     = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_oversampler_if #(.PRESCALE_W(PW)) bus3 ();
    uart_rx_oversampler_if #(.PRESCALE_W(PW)) bus5 ();

    assign bus3.sample_en = sample_en;
    assign bus3.Prescale  = prescale;
    assign bus5.sample_en = sample_en;
    assign bus5.Prescale  = prescale;

    uart_rx_oversampler #(.PRESCALE_W(PW), .N_SAMPLES(3), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX_IN (RX_IN),
        .bus   (bus3)
    );

    uart_rx_oversampler #(.PRESCALE_W(PW), .N_SAMPLES(5), .SYNC_STAGES(2)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .RX_IN (RX_IN),
        .bus   (bus5)
    );

    // Fill the per-tick RX pattern with one level.
    task automatic set_pat(input logic v);
        for (int i = 0; i < 64; i++) pat[i] = v;
    endtask

    // Expected vote for the current pattern, window centred at P/2.
    function automatic vote_t window_vote(input int p, input int n);
        vote_t v;
        int    c;
        int    h;
        int    ones;
        c    = p / 2;
        h    = (n - 1) / 2;
        ones = 0;
        for (int t = c - h; t <= c + h; t++) ones += int'(pat[t]);
        v.bit_v = (ones > h);
        v.noise = (ones != 0) && (ones != n);
        v.count = c + h + 1;
        return v;
    endfunction

    // One clock: advance the edge-counter model and drive RX so that the
    // synchronised line shows pat[tick] two cycles later.
    task automatic cycle();
        logic en_c;
        logic rst_c;
        int   p_c;
        en_c  = sample_en;
        rst_c = rst_n;
        p_c   = int'(prescale);
        @(posedge clk);
        #1;
        if (!rst_c || !rst_n) begin
            m_count = 0;
            m_cfg   = 1'b0;
        end else begin
            m_cfg = !(((p_c % 2) == 0) && (p_c >= 4));
            if (!en_c) m_count = 0;
            else if (m_count >= p_c - 1) m_count = 0;
            else m_count = m_count + 1;
        end
        RX_IN = pat[(m_count + 2) % int'(prescale)];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        sample_en = 1'b0;
        prescale  = PW'(16);
        RX_IN     = 1'b1;
        set_pat(1'b1);
        m_count   = 0;
        m_cfg     = 1'b0;
        #12;
        vectors++;
        if (bus3.edge_count !== '0 || bus3.bit_tick !== 1'b0 || bus3.sampled_bit !== 1'b1 ||
            bus3.sampled_valid !== 1'b0 || bus3.cfg_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got cnt=%0d tick=%b bit=%b valid=%b cfg=%b expected 0 0 1 0 0",
                     bus3.edge_count, bus3.bit_tick, bus3.sampled_bit, bus3.sampled_valid, bus3.cfg_err);
        end
`ifdef NOISE_FLAG_EN
        vectors++;
        if (bus3.noise_flag !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_noise: got %b expected 0", bus3.noise_flag);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        vectors++;
        if (bus3.cfg_err !== m_cfg || bus3.edge_count !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got cfg=%b cnt=%0d expected cfg=%b cnt=0",
                     bus3.cfg_err, bus3.edge_count, m_cfg);
        end
    endtask

    task automatic test_constant_zero();
        prescale = PW'(16);
        set_pat(1'b0);
        idle(3);
        sample_en = 1'b1;
        for (int b = 0; b < 3; b++) q3.push_back(window_vote(16, 3));
        for (int i = 0; i < 50; i++) begin
            cycle();
            vectors++;
            if (bus3.edge_count !== PW'(m_count) || bus3.bit_tick !== (m_count == 15)) begin
                miscompares++;
                $display("[TB] FAIL zero_counter: got cnt=%0d tick=%b expected cnt=%0d tick=%b",
                         bus3.edge_count, bus3.bit_tick, m_count, (m_count == 15));
            end
            if (bus3.sampled_valid === 1'b1) begin
                vectors++;
                if (q3.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL zero_extra_valid: got valid=1 expected valid=0");
                end else begin
                    exp_v = q3.pop_front();
                    if (bus3.sampled_bit !== exp_v.bit_v || int'(bus3.edge_count) != exp_v.count) begin
                        miscompares++;
                        $display("[TB] FAIL zero_vote: got bit=%b at cnt=%0d expected bit=%b at cnt=%0d",
                                 bus3.sampled_bit, bus3.edge_count, exp_v.bit_v, exp_v.count);
                    end
                end
            end
        end
        vectors++;
        if (q3.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL zero_missing_votes: got %0d pending expected 0", q3.size());
            q3.delete();
        end
        sample_en = 1'b0;
        cycle();
    endtask

    task automatic test_enable_drop();
        int guard;
        prescale = PW'(16);
        set_pat(1'b1);
        idle(3);
        sample_en = 1'b1;
        guard     = 0;
        while (m_count != 8 && guard < 40) begin
            cycle();
            guard++;
            vectors++;
            if (bus3.sampled_valid !== 1'b0 || bus3.edge_count !== PW'(m_count)) begin
                miscompares++;
                $display("[TB] FAIL drop_prewindow: got valid=%b cnt=%0d expected valid=0 cnt=%0d",
                         bus3.sampled_valid, bus3.edge_count, m_count);
            end
        end
        sample_en = 1'b0;
        cycle();
        vectors++;
        if (bus3.edge_count !== '0 || bus3.sampled_valid !== 1'b0 || bus3.sampled_bit !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drop_state: got cnt=%0d valid=%b bit=%b expected cnt=0 valid=0 bit=0",
                     bus3.edge_count, bus3.sampled_valid, bus3.sampled_bit);
        end
        set_pat(1'b0);
        pat[8] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if (bus3.sampled_valid !== 1'b0 || bus3.sampled_bit !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL drop_idle: got valid=%b bit=%b expected valid=0 bit=0",
                         bus3.sampled_valid, bus3.sampled_bit);
            end
        end
        sample_en = 1'b1;
        q3.push_back(window_vote(16, 3));
        for (int i = 0; i < 18; i++) begin
            cycle();
            if (bus3.sampled_valid === 1'b1) begin
                vectors++;
                if (q3.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL drop_extra_valid: got valid=1 expected valid=0");
                end else begin
                    exp_v = q3.pop_front();
                    if (bus3.sampled_bit !== exp_v.bit_v || int'(bus3.edge_count) != exp_v.count) begin
                        miscompares++;
                        $display("[TB] FAIL drop_fresh_vote: got bit=%b at cnt=%0d expected bit=%b at cnt=%0d",
                                 bus3.sampled_bit, bus3.edge_count, exp_v.bit_v, exp_v.count);
                    end
`ifdef NOISE_FLAG_EN
                    if (bus3.noise_flag !== exp_v.noise) begin
                        miscompares++;
                        $display("[TB] FAIL drop_noise: got %b expected %b", bus3.noise_flag, exp_v.noise);
                    end
`endif
                end
            end
        end
        vectors++;
        if (q3.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drop_missing_vote: got %0d pending expected 0", q3.size());
            q3.delete();
        end
        sample_en = 1'b0;
        cycle();
    endtask

    task automatic test_glitch_vote();
        prescale = PW'(8);
        set_pat(1'b0);
        pat[3] = 1'b1;
        pat[4] = 1'b1;
        idle(4);
        sample_en = 1'b1;
        q3.push_back(window_vote(8, 3));
        q5.push_back(window_vote(8, 5));
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus3.sampled_valid === 1'b1) begin
                vectors++;
                if (q3.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL glitch3_extra_valid: got valid=1 expected valid=0");
                end else begin
                    exp_v = q3.pop_front();
                    if (bus3.sampled_bit !== exp_v.bit_v || int'(bus3.edge_count) != exp_v.count) begin
                        miscompares++;
                        $display("[TB] FAIL glitch3_vote: got bit=%b at cnt=%0d expected bit=%b at cnt=%0d",
                                 bus3.sampled_bit, bus3.edge_count, exp_v.bit_v, exp_v.count);
                    end
`ifdef NOISE_FLAG_EN
                    if (bus3.noise_flag !== exp_v.noise) begin
                        miscompares++;
                        $display("[TB] FAIL glitch3_noise: got %b expected %b", bus3.noise_flag, exp_v.noise);
                    end
`endif
                end
            end
            if (bus5.sampled_valid === 1'b1) begin
                vectors++;
                if (q5.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL glitch5_extra_valid: got valid=1 expected valid=0");
                end else begin
                    exp_v = q5.pop_front();
                    if (bus5.sampled_bit !== exp_v.bit_v || int'(bus5.edge_count) != exp_v.count) begin
                        miscompares++;
                        $display("[TB] FAIL glitch5_vote: got bit=%b at cnt=%0d expected bit=%b at cnt=%0d",
                                 bus5.sampled_bit, bus5.edge_count, exp_v.bit_v, exp_v.count);
                    end
`ifdef NOISE_FLAG_EN
                    if (bus5.noise_flag !== exp_v.noise) begin
                        miscompares++;
                        $display("[TB] FAIL glitch5_noise: got %b expected %b", bus5.noise_flag, exp_v.noise);
                    end
`endif
                end
            end
        end
        vectors++;
        if (q3.size() != 0 || q5.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL glitch_missing_votes: got %0d/%0d pending expected 0/0", q3.size(), q5.size());
            q3.delete();
            q5.delete();
        end
        sample_en = 1'b0;
        cycle();
    endtask

    task automatic test_cfg_err();
        sample_en = 1'b0;
        prescale  = PW'(15);
        set_pat(1'b1);
        cycle();
        vectors++;
        if (bus3.cfg_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL cfg_set: got %b expected 1", bus3.cfg_err);
        end
        sample_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            vectors++;
            if (bus3.edge_count !== PW'(m_count) || bus3.cfg_err !== 1'b1 || bus3.sampled_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL cfg_run: got cnt=%0d cfg=%b valid=%b expected cnt=%0d cfg=1 valid=0",
                         bus3.edge_count, bus3.cfg_err, bus3.sampled_valid, m_count);
            end
        end
        sample_en = 1'b0;
        prescale  = PW'(16);
        cycle();
        vectors++;
        if (bus3.cfg_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL cfg_clear: got %b expected 0", bus3.cfg_err);
        end
        idle(2);
        sample_en = 1'b1;
        q3.push_back(window_vote(16, 3));
        for (int i = 0; i < 18; i++) begin
            cycle();
            if (bus3.sampled_valid === 1'b1) begin
                vectors++;
                if (q3.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL cfg_extra_valid: got valid=1 expected valid=0");
                end else begin
                    exp_v = q3.pop_front();
                    if (bus3.sampled_bit !== exp_v.bit_v || int'(bus3.edge_count) != exp_v.count) begin
                        miscompares++;
                        $display("[TB] FAIL cfg_restored_vote: got bit=%b at cnt=%0d expected bit=%b at cnt=%0d",
                                 bus3.sampled_bit, bus3.edge_count, exp_v.bit_v, exp_v.count);
                    end
                end
            end
        end
        vectors++;
        if (q3.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL cfg_missing_vote: got %0d pending expected 0", q3.size());
            q3.delete();
        end
        sample_en = 1'b0;
        cycle();
    endtask

    task automatic test_prescale_shrink();
        int guard;
        prescale = PW'(32);
        set_pat(1'b0);
        idle(3);
        sample_en = 1'b1;
        q3.push_back(window_vote(32, 3));
        guard = 0;
        while (m_count != 20 && guard < 60) begin
            cycle();
            guard++;
            vectors++;
            if (bus3.edge_count !== PW'(m_count) || bus3.bit_tick !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL shrink_p32: got cnt=%0d tick=%b expected cnt=%0d tick=0",
                         bus3.edge_count, bus3.bit_tick, m_count);
            end
            if (bus3.sampled_valid === 1'b1) begin
                vectors++;
                if (q3.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL shrink_extra_valid: got valid=1 expected valid=0");
                end else begin
                    exp_v = q3.pop_front();
                    if (bus3.sampled_bit !== exp_v.bit_v || int'(bus3.edge_count) != exp_v.count) begin
                        miscompares++;
                        $display("[TB] FAIL shrink_p32_vote: got bit=%b at cnt=%0d expected bit=%b at cnt=%0d",
                                 bus3.sampled_bit, bus3.edge_count, exp_v.bit_v, exp_v.count);
                    end
                end
            end
        end
        prescale = PW'(8);
        #1;
        vectors++;
        if (bus3.bit_tick !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL shrink_stale_tick: got %b expected 0", bus3.bit_tick);
        end
        q3.push_back(window_vote(8, 3));
        for (int i = 0; i < 10; i++) begin
            cycle();
            vectors++;
            if (bus3.edge_count !== PW'(m_count) || bus3.bit_tick !== (m_count == 7)) begin
                miscompares++;
                $display("[TB] FAIL shrink_p8: got cnt=%0d tick=%b expected cnt=%0d tick=%b",
                         bus3.edge_count, bus3.bit_tick, m_count, (m_count == 7));
            end
            if (bus3.sampled_valid === 1'b1) begin
                vectors++;
                if (q3.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL shrink_extra_valid: got valid=1 expected valid=0");
                end else begin
                    exp_v = q3.pop_front();
                    if (bus3.sampled_bit !== exp_v.bit_v || int'(bus3.edge_count) != exp_v.count) begin
                        miscompares++;
                        $display("[TB] FAIL shrink_p8_vote: got bit=%b at cnt=%0d expected bit=%b at cnt=%0d",
                                 bus3.sampled_bit, bus3.edge_count, exp_v.bit_v, exp_v.count);
                    end
                end
            end
        end
        vectors++;
        if (q3.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL shrink_missing_votes: got %0d pending expected 0", q3.size());
            q3.delete();
        end
        sample_en = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid_window();
        int guard;
        prescale = PW'(16);
        set_pat(1'b1);
        idle(3);
        sample_en = 1'b1;
        guard     = 0;
        while (m_count != 8 && guard < 40) begin
            cycle();
            guard++;
        end
        rst_n   = 1'b0;
        m_count = 0;
        #2;
        vectors++;
        if (bus3.edge_count !== '0 || bus3.bit_tick !== 1'b0 || bus3.sampled_bit !== 1'b1 ||
            bus3.sampled_valid !== 1'b0 || bus3.cfg_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_values: got cnt=%0d tick=%b bit=%b valid=%b cfg=%b expected 0 0 1 0 0",
                     bus3.edge_count, bus3.bit_tick, bus3.sampled_bit, bus3.sampled_valid, bus3.cfg_err);
        end
        cycle();
        rst_n = 1'b1;
        q3.push_back(window_vote(16, 3));
        for (int i = 0; i < 20; i++) begin
            cycle();
            vectors++;
            if (bus3.edge_count !== PW'(m_count)) begin
                miscompares++;
                $display("[TB] FAIL midrst_counter: got %0d expected %0d", bus3.edge_count, m_count);
            end
            if (bus3.sampled_valid === 1'b1) begin
                vectors++;
                if (q3.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL midrst_extra_valid: got valid=1 expected valid=0");
                end else begin
                    exp_v = q3.pop_front();
                    if (bus3.sampled_bit !== exp_v.bit_v || int'(bus3.edge_count) != exp_v.count) begin
                        miscompares++;
                        $display("[TB] FAIL midrst_first_vote: got bit=%b at cnt=%0d expected bit=%b at cnt=%0d",
                                 bus3.sampled_bit, bus3.edge_count, exp_v.bit_v, exp_v.count);
                    end
                end
            end
        end
        vectors++;
        if (q3.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL midrst_missing_vote: got %0d pending expected 0", q3.size());
            q3.delete();
        end
        sample_en = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_constant_zero();
        test_enable_drop();
        test_glitch_vote();
        test_cfg_err();
        test_prescale_shrink();
        test_reset_mid_window();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
